// File: rtl/aeolus_pkg.sv
// Aeolus CPU shared definitions.
// Sequencer state encodings and opcode constants.
package aeolus_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_FETCH = 2'b01,
    SEQ_EXEC  = 2'b10,
    SEQ_HALT  = 2'b11
  } seq_state_t;

  localparam int SKIP_INC = 2;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SNZA = 4'hc;
  localparam logic [3:0] OP_SNZS = 4'hd;

endpackage

// File: rtl/aeolus_step_capture.sv
// Step button edge detector with a pending flag.
// The flag survives until the sequencer consumes it.
module aeolus_step_capture (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic consume,
  output logic step_pend
);

  logic step_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_prev <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_prev <= step;
      // a fresh edge wins over a same-cycle consume
      step_pend <= (step_pend & ~consume) | (step & ~step_prev);
    end
  end

endmodule

// File: rtl/aeolus_sequencer.sv
// Aeolus fetch/execute sequencer.
// Owns PC and IR; one execute strobe per instruction.
module aeolus_sequencer
  import aeolus_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int OPCODE_WIDTH = 4,
  parameter bit HALT_ON_WRAP = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    step,
  input  logic [OPCODE_WIDTH-1:0] opcodeIn,
  input  logic                    skipCond,
  output logic [ADDR_WIDTH-1:0]   pcOut,
  output logic [OPCODE_WIDTH-1:0] instrOut,
  output logic                    execEn,
  output logic                    halted,
  output logic [1:0]              stateOut
);

  localparam logic [ADDR_WIDTH:0] INC_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] INC_SKIP = (ADDR_WIDTH+1)'(SKIP_INC);

  seq_state_t              state, state_n;
  logic [ADDR_WIDTH-1:0]   pc_n;
  logic [OPCODE_WIDTH-1:0] ir_n;
  logic [ADDR_WIDTH:0]     sum;
  logic                    step_pend;
  logic                    consume;

  aeolus_step_capture u_step (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .consume   (consume),
    .step_pend (step_pend)
  );

  assign sum = {1'b0, pcOut} + (skipCond ? INC_SKIP : INC_ONE);

  // pending steps only matter while stopped; otherwise they are dropped
  assign consume = tick & (run | (state == SEQ_IDLE) | (state == SEQ_HALT));

  always_comb begin
    state_n = state;
    pc_n    = pcOut;
    ir_n    = instrOut;
    if (tick) begin
      unique case (state)
        SEQ_IDLE: begin
          if (run || step_pend) state_n = SEQ_FETCH;
        end
        SEQ_FETCH: begin
          ir_n    = opcodeIn;
          state_n = SEQ_EXEC;
        end
        SEQ_EXEC: begin
          if (HALT_ON_WRAP && sum[ADDR_WIDTH]) begin
            pc_n    = '0;
            state_n = SEQ_HALT;
          end else begin
            pc_n    = sum[ADDR_WIDTH-1:0];
            state_n = run ? SEQ_FETCH : SEQ_IDLE;
          end
        end
        SEQ_HALT: begin
          if (step_pend && !run) state_n = SEQ_IDLE;
        end
        default: state_n = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEQ_IDLE;
      pcOut    <= '0;
      instrOut <= '0;
    end else begin
      state    <= state_n;
      pcOut    <= pc_n;
      instrOut <= ir_n;
    end
  end

  assign execEn   = (state == SEQ_EXEC) & tick;
  assign halted   = (state == SEQ_HALT);
  assign stateOut = state;

endmodule

// File: tb/tb_aeolus_sequencer.sv
// Directed bench for aeolus_sequencer.
// Two instances: halt-on-wrap and wrap-around.
module tb_aeolus_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       run;
  logic       step;
  logic       skip;
  logic [3:0] op_h, op_w;
  logic [4:0] pc_h, pc_w;
  logic [3:0] ir_h, ir_w;
  logic       ex_h, ex_w;
  logic       hl_h, hl_w;
  logic [1:0] st_h, st_w;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] rom(input logic [4:0] a);
    return a[3:0] ^ 4'ha;
  endfunction

  assign op_h = rom(pc_h);
  assign op_w = rom(pc_w);

  aeolus_sequencer #(
    .ADDR_WIDTH(5), .OPCODE_WIDTH(4), .HALT_ON_WRAP(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run),
    .step(step), .opcodeIn(op_h), .skipCond(skip),
    .pcOut(pc_h), .instrOut(ir_h), .execEn(ex_h),
    .halted(hl_h), .stateOut(st_h)
  );

  aeolus_sequencer #(
    .ADDR_WIDTH(5), .OPCODE_WIDTH(4), .HALT_ON_WRAP(1'b0)
  ) dut_w (
    .clk(clk), .reset(reset), .tick(tick), .run(run),
    .step(step), .opcodeIn(op_w), .skipCond(skip),
    .pcOut(pc_w), .instrOut(ir_w), .execEn(ex_w),
    .halted(hl_w), .stateOut(st_w)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick  = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    skip  = 1'b0;
    tk();
    tk();
    reset = 1'b1;
  endtask

  task automatic run_to(input logic [4:0] target);
    int i = 0;
    while (!(st_h == 2'b10 && pc_h == target) && i < 200) begin
      tk();
      i++;
    end
    check("reach", {st_h, pc_h}, {2'b10, target});
  endtask

  task automatic step_window(input int s1, input int s2,
                             output int pulses);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tk();
      tick = (c % 8 == 7);
      step = (c == s1) || (c == s2);
      #1;
      if (ex_h) pulses++;
    end
    tick = 1'b0;
    step = 1'b0;
  endtask

  int pulses;

  initial begin
    do_reset();
    reset = 1'b0;
    #1;
    check("rst_pc", pc_h, 0);
    check("rst_ir", ir_h, 0);
    check("rst_ex", ex_h, 0);
    check("rst_halt", hl_h, 0);
    check("rst_state", st_h, 0);
    tk();
    reset = 1'b1;

    // free run, pc advances every two ticks
    run  = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tk();
      check("run_fetch", {st_h, pc_h, 3'b0, ex_h}, {2'b01, 5'(i), 4'h0});
      tk();
      check("run_exec", {st_h, pc_h, 3'b0, ex_h}, {2'b10, 5'(i), 4'h1});
      check("run_ir", ir_h, rom(5'(i)));
    end

    // skip at 5 jumps straight to 7
    tk();
    tk();
    check("at5", {st_h, pc_h}, {2'b10, 5'd5});
    skip = 1'b1;
    tk();
    skip = 1'b0;
    check("skip_pc", pc_h, 7);
    tk();
    check("skip_ir", ir_h, rom(5'd7));

    // skip from 30 overflows: halt vs wrap
    run_to(5'd30);
    skip = 1'b1;
    tk();
    skip = 1'b0;
    check("h30_pc", pc_h, 0);
    check("h30_halt", {st_h, hl_h, ex_h}, {2'b11, 1'b1, 1'b0});
    check("w30_pc", {st_w, pc_w}, {2'b01, 5'd0});
    tk();
    tk();
    tk();
    check("halt_hold", {st_h, ex_h}, {2'b11, 1'b0});

    // step with run low leaves halt
    run  = 1'b0;
    step = 1'b1;
    tk();
    step = 1'b0;
    tk();
    check("halt_step", {st_h, hl_h}, {2'b00, 1'b0});

    // plain increment from 31
    do_reset();
    run  = 1'b1;
    tick = 1'b1;
    run_to(5'd31);
    tk();
    check("h31", {st_h, pc_h, hl_h}, {2'b11, 5'd0, 1'b1});
    check("w31", {st_w, pc_w, hl_w}, {2'b01, 5'd0, 1'b0});
    tk();
    check("h31_ex", ex_h, 0);
    check("w31_ex", {st_w, ex_w, ir_w}, {2'b10, 1'b1, rom(5'd0)});

    // single step, tick every 8 clks
    do_reset();
    step_window(2, -1, pulses);
    check("step1_pulses", pulses, 1);
    check("step1_pc", {st_h, pc_h}, {2'b00, 5'd1});
    step_window(1, 4, pulses);
    check("step2_pulses", pulses, 1);
    check("step2_pc", {st_h, pc_h}, {2'b00, 5'd2});

    // async reset in the middle of execute
    run  = 1'b1;
    tick = 1'b1;
    run_to(5'd9);
    check("pre_rst_ex", ex_h, 1);
    reset = 1'b0;
    #1;
    check("mid_rst", {st_h, pc_h, ir_h, ex_h, hl_h}, 13'h0);
    tk();
    tk();
    reset = 1'b1;
    tk();
    check("post_fetch", {st_h, pc_h}, {2'b01, 5'd0});
    tk();
    check("post_ir", {st_h, ir_h}, {2'b10, rom(5'd0)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
